// File: rtl/decrypt_ctrl_if.sv
// Plaintext output handshake for decrypt_ctrl.
// master drives valid/data, slave drives ready.
interface decrypt_ctrl_if #(
  parameter int PLAINTEXT_WIDTH = 8
);
  logic                       out_valid;
  logic                       out_ready;
  logic [PLAINTEXT_WIDTH-1:0] out_data;

  modport master (
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/decrypt_ctrl.sv
// LWE decrypt sequencer: row fetch, beat streaming, result capture.
// Optional cycle/job counters under DECRYPT_CTRL_PERF_EN.
module decrypt_ctrl #(
  parameter int PLAINTEXT_WIDTH  = 8,
  parameter int CIPHERTEXT_WIDTH = 16,
  parameter int DIMENSION        = 3,
  parameter int PARALLEL         = 2,
  parameter int RESULT_LATENCY   = 1,
  localparam int ROWS  = (DIMENSION + PARALLEL) / PARALLEL,
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int BUS_W = PARALLEL * CIPHERTEXT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       mem_rd_en,
  output logic [ROW_W-1:0]           mem_addr,
  input  logic [BUS_W-1:0]           sk_rdata,
  input  logic [BUS_W-1:0]           ct_rdata,
  output logic                       dec_en,
  output logic [ROW_W-1:0]           dec_row,
  output logic [BUS_W-1:0]           dec_sk_entry,
  output logic [BUS_W-1:0]           dec_ct_entry,
  input  logic [PLAINTEXT_WIDTH-1:0] dec_result,
  decrypt_ctrl_if.master             out_if
`ifdef DECRYPT_CTRL_PERF_EN
  ,
  output logic [31:0]                perf_count,
  output logic [15:0]                perf_jobs
`endif
);

  localparam int CW    = CIPHERTEXT_WIDTH;
  localparam int LAT_W = $clog2(RESULT_LATENCY + 1);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RESULT_LATENCY - 1);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    STREAM,
    DRAIN,
    HOLD
  } state_t;

  state_t                     state;
  logic [PARALLEL-1:0]        lane_en;
  logic [LAT_W-1:0]           lat_cnt;
  logic                       out_valid_q;
  logic [PLAINTEXT_WIDTH-1:0] out_data_q;

  function automatic logic [PARALLEL-1:0] row_mask(input int row);
    logic [PARALLEL-1:0] m;
    for (int i = 0; i < PARALLEL; i++) begin
      m[i] = (row * PARALLEL + i) <= DIMENSION;
    end
    return m;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      dec_en      <= 1'b0;
      dec_row     <= '0;
      lane_en     <= '0;
      lat_cnt     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (mem_rd_en) begin
        if (mem_addr == LAST_ROW) begin
          mem_rd_en <= 1'b0;
          mem_addr  <= '0;
        end else begin
          mem_addr <= mem_addr + ROW_ONE;
        end
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= FETCH;
            busy      <= 1'b1;
            mem_rd_en <= 1'b1;
            mem_addr  <= '0;
          end
        end
        FETCH: begin
          state   <= STREAM;
          dec_en  <= 1'b1;
          dec_row <= '0;
          lane_en <= row_mask(0);
        end
        STREAM: begin
          if (dec_row == LAST_ROW) begin
            state   <= DRAIN;
            dec_en  <= 1'b0;
            dec_row <= '0;
            lane_en <= '0;
            lat_cnt <= '0;
          end else begin
            dec_row <= dec_row + ROW_ONE;
            lane_en <= row_mask(int'(dec_row) + 1);
          end
        end
        DRAIN: begin
          if (lat_cnt == LAT_LAST) begin
            state       <= HOLD;
            out_valid_q <= 1'b1;
            out_data_q  <= dec_result;
          end else begin
            lat_cnt <= lat_cnt + LAT_ONE;
          end
        end
        HOLD: begin
          if (out_if.out_ready) begin
            state       <= IDLE;
            busy        <= 1'b0;
            out_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // rdata only arrives in the beat cycle, so entries are the
  // memory data gated by a registered per-lane enable.
  always_comb begin
    dec_sk_entry = '0;
    dec_ct_entry = '0;
    for (int i = 0; i < PARALLEL; i++) begin
      dec_sk_entry[i*CW +: CW] =
        sk_rdata[i*CW +: CW] & {CW{lane_en[i]}};
      dec_ct_entry[i*CW +: CW] =
        ct_rdata[i*CW +: CW] & {CW{lane_en[i]}};
    end
  end

  assign out_if.out_valid = out_valid_q;
  assign out_if.out_data  = out_data_q;

`ifdef DECRYPT_CTRL_PERF_EN
  // Acceptance cycle counts too: a job spans start..handshake.
  logic job_active;
  assign job_active = busy || (state == IDLE && start);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_count <= '0;
      perf_jobs  <= '0;
    end else begin
      if (job_active && perf_count != '1) begin
        perf_count <= perf_count + 32'd1;
      end
      if (out_valid_q && out_if.out_ready) begin
        perf_jobs <= perf_jobs + 16'd1;
      end
    end
  end
`endif

endmodule
